// File: rtl/wb_arbiter_pkg.sv
// Shared writeback types, default widths and the redirect squash test used by
// the arbiter and the execution units.
package wb_arbiter_pkg;

  localparam int WB_WIDTH = 4;
  localparam int OPID_W   = 16;

  typedef struct packed {
    logic [OPID_W-1:0] opid;
    logic              prdv;
    logic [6:0]        prd;
    logic [63:0]       data;
  } exe_bundle_t;

  typedef struct packed {
    logic [OPID_W-1:0] opid;
    logic [OPID_W-1:0] topid;
  } red_bundle_t;

  // True when opid is younger than the redirecting op; ages are taken
  // relative to topid modulo 2**obits so wrap-around stays ordered.
  function automatic logic succeed(input logic [OPID_W-1:0] opid,
                                   input red_bundle_t       redir,
                                   input int unsigned       obits);
    logic [OPID_W-1:0] mask;
    logic [OPID_W-1:0] age;
    logic [OPID_W-1:0] lim;
    mask = OPID_W'((32'd1 << obits) - 32'd1);
    age  = (opid - redir.topid) & mask;
    lim  = (redir.opid - redir.topid + 16'd1) & mask;
    return redir.opid[15] & opid[15] & (age >= lim);
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the execution units and the writeback arbiter.
interface wb_arbiter_if
  import wb_arbiter_pkg::*;
#(
  parameter int nfu = 4,
  parameter int ewd = 4,
  parameter int wbw = WB_WIDTH
) ();

  red_bundle_t                   redir;
  exe_bundle_t [nfu*ewd-1:0]     resp;
  logic        [nfu*ewd-1:0]     claim;
  exe_bundle_t [wbw-1:0]         wb;
  logic        [nfu-1:0]         busy;

  modport slave (
    input  redir,
    input  resp,
    output claim,
    output wb,
    output busy
  );

  modport master (
    output redir,
    output resp,
    input  claim,
    input  wb,
    input  busy
  );

endinterface

// File: rtl/wb_arbiter_rr_select.sv
// Rotating first-k selector: scans n request bits from base upward with wrap
// and grants the first k set bits, reporting their indices in grant order.
module wb_arbiter_rr_select #(
  parameter  int n  = 16,
  parameter  int k  = 4,
  localparam int IW = (n > 1) ? $clog2(n) : 1,
  localparam int CW = $clog2(k + 1),
  localparam int SW = (k > 1) ? $clog2(k) : 1
) (
  input  logic [n-1:0]          req,
  input  logic [IW-1:0]         base,
  output logic [n-1:0]          gnt,
  output logic [k-1:0][IW-1:0]  idx,
  output logic [CW-1:0]         cnt
);

  logic [IW:0]   sum_s;
  logic [IW-1:0] pos_s;

  // Walk the requests in rotated order, taking the first k
  always_comb begin
    gnt   = '0;
    idx   = '0;
    cnt   = '0;
    sum_s = '0;
    pos_s = '0;
    for (int i = 0; i < n; i++) begin
      sum_s = {1'b0, base} + (IW+1)'(i);
      pos_s = (sum_s >= (IW+1)'(n)) ? IW'(sum_s - (IW+1)'(n)) : IW'(sum_s);
      if (req[pos_s] && (cnt < CW'(k))) begin
        gnt[pos_s]        = 1'b1;
        idx[cnt[SW-1:0]]  = pos_s;
        cnt               = cnt + CW'(1);
      end else begin
        gnt[pos_s] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: grants up to wbw unit results per cycle with rotating
// fairness and registers them onto the writeback bus. WB_ARBITER_PERF_EN adds
// per-unit conflict counters.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int nfu  = 4,
  parameter int ewd  = 4,
  parameter int wbw  = WB_WIDTH,
  parameter int opsz = 64
) (
  input  logic             clk,
  input  logic             rst,
  wb_arbiter_if.slave      bus
`ifdef WB_ARBITER_PERF_EN
  ,
  output logic [nfu-1:0][31:0] perf_conflict
`endif
);

  localparam int NL = nfu * ewd;
  localparam int IW = (NL > 1) ? $clog2(NL) : 1;
  localparam int RW = (nfu > 1) ? $clog2(nfu) : 1;
  localparam int CW = $clog2(wbw + 1);
  localparam int OB = $clog2(opsz);

  logic [NL-1:0]             req_s;
  logic [NL-1:0]             gnt_s;
  logic [wbw-1:0][IW-1:0]    idx_s;
  logic [CW-1:0]             cnt_s;
  logic [IW-1:0]             base_s;
  logic [IW-1:0]             last_idx_s;
  logic [RW-1:0]             last_unit_s;
  logic [nfu-1:0]            busy_s;
  logic [RW-1:0]             rr_q, rr_d;
  exe_bundle_t [wbw-1:0]     wb_q, wb_d;

  // Requests are masked during reset so nothing is claimed across it
  always_comb begin
    req_s = '0;
    for (int k = 0; k < NL; k++) begin
      req_s[k] = bus.resp[k].opid[15] & ~rst;
    end
  end

  assign base_s = IW'(rr_q) * IW'(ewd);

  wb_arbiter_rr_select #(
    .n (NL),
    .k (wbw)
  ) u_sel (
    .req  (req_s),
    .base (base_s),
    .gnt  (gnt_s),
    .idx  (idx_s),
    .cnt  (cnt_s)
  );

  // Claims and per-unit stall hints
  always_comb begin
    busy_s    = '0;
    bus.claim = gnt_s;
    for (int u = 0; u < nfu; u++) begin
      busy_s[u] = |(req_s[u*ewd +: ewd] & ~gnt_s[u*ewd +: ewd]);
    end
    bus.busy = busy_s;
  end

  // Pack granted lanes in grant order; lanes squashed now are kept with opid 0
  always_comb begin
    wb_d        = '0;
    rr_d        = rr_q;
    last_idx_s  = '0;
    last_unit_s = '0;
    for (int j = 0; j < wbw; j++) begin
      if (CW'(j) < cnt_s) begin
        wb_d[j]      = bus.resp[idx_s[j]];
        wb_d[j].opid = succeed(wb_d[j].opid, bus.redir, OB) ? 16'h0000 : wb_d[j].opid;
        last_idx_s   = idx_s[j];
      end else begin
        wb_d[j] = '0;
      end
    end
    last_unit_s = RW'(last_idx_s / IW'(ewd));
    if (cnt_s != '0) begin
      rr_d = (last_unit_s == RW'(nfu - 1)) ? '0 : last_unit_s + RW'(1);
    end else begin
      rr_d = rr_q;
    end
  end

  // Writeback register and rotation pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q <= '0;
      rr_q <= '0;
    end else begin
      wb_q <= wb_d;
      rr_q <= rr_d;
    end
  end

  // A redirect arriving one cycle late still kills the registered result
  always_comb begin
    bus.wb = wb_q;
    for (int j = 0; j < wbw; j++) begin
      bus.wb[j].opid = succeed(wb_q[j].opid, bus.redir, OB) ? 16'h0000 : wb_q[j].opid;
    end
  end

`ifdef WB_ARBITER_PERF_EN
  logic [nfu-1:0][31:0] perf_q, perf_d;

  // Saturating count of cycles each unit was left waiting
  always_comb begin
    perf_d = perf_q;
    for (int u = 0; u < nfu; u++) begin
      perf_d[u] = (busy_s[u] && (perf_q[u] != 32'hffff_ffff)) ? perf_q[u] + 32'd1 : perf_q[u];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_conflict = perf_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: claims/busy checked in-cycle, writeback and
// pointer expectations queued and checked one cycle later by a monitor.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_arbiter_if #(.nfu(4), .ewd(4), .wbw(4)) bus ();

`ifdef WB_ARBITER_PERF_EN
  logic [3:0][31:0] perf_conflict;
`endif

  wb_arbiter #(.nfu(4), .ewd(4), .wbw(4), .opsz(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef WB_ARBITER_PERF_EN
    ,
    .perf_conflict (perf_conflict)
`endif
  );

  typedef struct {
    logic [63:0]      wb;
    logic [1:0]       rr;
    logic [3:0][31:0] perf;
    int               due;
  } exp_t;

  exp_t             sb[$];
  int               cyc = 0;
  int               errors = 0;
  int               checks = 0;
  logic [3:0][31:0] exp_perf;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  // One cycle of stimulus: lane k carries opid base+k when mask[k] is set
  task automatic run(input logic r, input logic [15:0] mask, input logic [15:0] base,
                     input logic [15:0] rop, input logic [15:0] eclaim, input logic [3:0] ebusy,
                     input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                     input logic [15:0] w3, input logic [1:0] err);
    exp_t e;
    @(negedge clk);
    rst = r;
    for (int k = 0; k < 16; k++) begin
      bus.resp[k] = '0;
      if (mask[k]) begin
        bus.resp[k].opid = base + 16'(k);
        bus.resp[k].prdv = 1'b1;
        bus.resp[k].data = 64'(k);
      end
    end
    bus.redir.opid  = rop;
    bus.redir.topid = 16'h0000;
    if (r) begin
      exp_perf = '0;
    end else begin
      for (int u = 0; u < 4; u++) exp_perf[u] = exp_perf[u] + 32'(ebusy[u]);
    end
    e.wb   = {w0, w1, w2, w3};
    e.rr   = err;
    e.perf = exp_perf;
    e.due  = cyc + 1;
    sb.push_back(e);
    #2;
    check("claim", 64'(bus.claim), 64'(eclaim));
    check("busy", 64'(bus.busy), 64'(ebusy));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        check("wb_opid", {bus.wb[0].opid, bus.wb[1].opid, bus.wb[2].opid, bus.wb[3].opid}, e.wb);
        check("rr", 64'(dut.rr_q), 64'(e.rr));
`ifdef WB_ARBITER_PERF_EN
        for (int u = 0; u < 4; u++) check("perf", 64'(perf_conflict[u]), 64'(e.perf[u]));
`endif
      end
    end
  end

  initial begin : stimulus
    bus.resp  = '0;
    bus.redir = '0;
    exp_perf  = '0;
    //  rst   mask      base      redir     claim     busy     wb0       wb1       wb2       wb3       rr
    run(1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'd0);
    run(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'd0);
    run(1'b0, 16'h0100, 16'h7ffd, 16'h0000, 16'h0100, 4'b0000, 16'h8005, 16'h0000, 16'h0000, 16'h0000, 2'd3);
    run(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'd3);
    run(1'b0, 16'h2000, 16'h8000, 16'h0000, 16'h2000, 4'b0000, 16'h800d, 16'h0000, 16'h0000, 16'h0000, 2'd0);
    // saturation
    run(1'b0, 16'hffff, 16'h8000, 16'h0000, 16'h000f, 4'b1110, 16'h8000, 16'h8001, 16'h8002, 16'h8003, 2'd1);
    run(1'b0, 16'hffff, 16'h8000, 16'h0000, 16'h00f0, 4'b1101, 16'h8004, 16'h8005, 16'h8006, 16'h8007, 2'd2);
    // fairness between unit0 and unit3
    run(1'b0, 16'hf00f, 16'h8000, 16'h0000, 16'hf000, 4'b0001, 16'h800c, 16'h800d, 16'h800e, 16'h800f, 2'd0);
    run(1'b0, 16'hf00f, 16'h8000, 16'h0000, 16'h000f, 4'b1000, 16'h8000, 16'h8001, 16'h8002, 16'h8003, 2'd1);
    run(1'b0, 16'hf00f, 16'h8000, 16'h0000, 16'hf000, 4'b0001, 16'h800c, 16'h800d, 16'h800e, 16'h800f, 2'd0);
    // scattered lanes across units
    run(1'b0, 16'h2586, 16'h8000, 16'h0000, 16'h0186, 4'b1100, 16'h8001, 16'h8002, 16'h8007, 16'h8008, 2'd3);
    run(1'b0, 16'h2586, 16'h8000, 16'h0000, 16'h2086, 4'b0100, 16'h800d, 16'h8001, 16'h8002, 16'h8007, 2'd2);
    // squash at grant: 8012 dropped, 800f kept
    run(1'b0, 16'h9000, 16'h8003, 16'h8010, 16'h9000, 4'b0000, 16'h800f, 16'h0000, 16'h0000, 16'h0000, 2'd0);
    // squash at output by next-cycle redirect 801e
    run(1'b0, 16'h0001, 16'h8020, 16'h0000, 16'h0001, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'd1);
    run(1'b0, 16'h0000, 16'h0000, 16'h801e, 16'h0000, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'd1);
    // reset with three results in flight
    run(1'b0, 16'h0070, 16'h8000, 16'h0000, 16'h0070, 4'b0000, 16'h8004, 16'h8005, 16'h8006, 16'h0000, 2'd2);
    run(1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'd0);
    run(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'd0);

    for (int i = 0; i < 4; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
      #3;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries pending, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
